fc_weight_loader: RTL and testbench
===================================

Name: fc_weight_loader

Overview:
- Upstream feeder for the fully connected weight memory.
- Accepts fully connected weights one word per beat over a valid/ready stream and assembles them in a staging buffer.
- Once all FLATTENED_LENGTH words are staged, it presents the parallel vector and drives the active-low write enable for exactly one clk cycle, so the memory (which samples on negedge clk) commits the whole set atomically.
- The memory contents never show a partial weight set.

Parameters:
FLATTENED_LENGTH, 50, number of weights per set; must be at least 2.
FULLYCONNECTED_DATA_WIDTH, 8, bits per weight.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
load_start  input  1  request a new load; honoured only in IDLE.
load_abort  input  1  discard the load in progress; return to IDLE without committing.
weight_in_valid  input  1  stream word valid.
weight_in  input  FULLYCONNECTED_DATA_WIDTH  stream word.
weight_in_ready  output  1  loader can accept a word this cycle.
fullyconnected_weights_input  output  FULLYCONNECTED_DATA_WIDTH x [FLATTENED_LENGTH]  staging buffer, driven straight to the memory.
fullyconnected_WrEn  output  1  memory write enable, active-low.
busy  output  1  high in every state except IDLE.
load_done  output  1  one-cycle pulse after a successful commit.
load_error  output  1  one-cycle pulse on abort or checksum failure.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, index=0, staging all zeros.
  - fullyconnected_WrEn=1; weight_in_ready=0; busy=0; load_done=0; load_error=0.
  - Reset overrides every other input, including mid-load and during COMMIT. In COMMIT, WrEn returns to 1 at the same edge.
- States: IDLE, LOAD, CHECK (only with the optional feature), COMMIT.
- IDLE:
  - ready=0.
  - load_start=1 moves to LOAD and clears index to 0.
  - Staging keeps its old contents; they are overwritten during the load.
- LOAD:
  - ready=1.
  - A beat is accepted when valid&ready: staging[index] <= weight_in, index++.
  - The first accepted word goes to index 0. Beats with valid=0 are stalls with no limit.
  - When the beat at index FLATTENED_LENGTH-1 is accepted, go to COMMIT (or to CHECK with the feature).
  - load_start is ignored whenever state != IDLE.
- COMMIT:
  - Lasts exactly one cycle. ready=0. fullyconnected_WrEn is registered and is 0 for this whole cycle only.
  - Staging is held stable throughout, so the memory samples it at the negedge inside the cycle.
  - Next state is IDLE, with load_done=1 for that one cycle.
- Latency:
  - Last beat accepted at edge T: WrEn=0 between T and T+1; load_done=1 between T+1 and T+2.
  - Back-to-back: load_start may be asserted in the load_done cycle and starts LOAD at the next edge.
- Abort:
  - load_abort=1 in LOAD or CHECK goes to IDLE with load_error pulsed for one cycle, and no WrEn.
  - A beat presented in the same cycle as abort is not written to staging.
  - Abort is ignored in IDLE and COMMIT; a commit always completes.
- Index width is $clog2(FLATTENED_LENGTH); it never exceeds FLATTENED_LENGTH-1.

Optional Feature:
Macro FC_LOADER_CHECKSUM_EN.
- Defined:
  - A running sum of accepted weights is kept, modulo 2^FULLYCONNECTED_DATA_WIDTH, and cleared on load_start.
  - After the last weight, state CHECK raises ready and accepts exactly one extra word as the checksum.
  - Match: go to COMMIT.
  - Mismatch: go to IDLE with a load_error pulse and no WrEn.
- Undefined: CHECK does not exist, LOAD goes directly to COMMIT, and there is no sum register.

Decomposition:
- Package fc_pkg holds:
  - the state enum typedef fc_load_state_t;
  - default localparams for FLATTENED_LENGTH and FULLYCONNECTED_DATA_WIDTH, shared with FullyConnectedMem instantiations.
- Natural sub-module fc_load_index_counter: a clear/increment counter with a terminal-count flag at FLATTENED_LENGTH-1. Everything else stays inline.

Test Plan:
- Reset, then load_start, then 50 consecutive beats with values 1..50: WrEn is low exactly one cycle after the 50th beat, staging[0]=1 and staging[49]=50, load_done pulses on the following cycle, busy returns to 0.
- Same load with valid toggled 1/0 every cycle: 50 accepted beats with identical staging contents; WrEn is never low before the 50th accepted beat.
- load_abort after 20 beats: no WrEn, load_error pulses, busy=0. A following full load of 0xAA words commits all 0xAA.
- load_start pulsed during LOAD at beat 10: ignored; index continues to 11 and the commit happens after beat 50.
- rst asserted on the COMMIT cycle edge: WrEn=1, ready=0, staging all 0, load_done never pulses.
- With FC_LOADER_CHECKSUM_EN: all weights 0x05 with checksum 0xFA (250 mod 256) commits; checksum 0xFB gives load_error and no WrEn.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully connected weight loader.
// FC_LOADER_CHECKSUM_EN adds the CHECK state to the state enum.
package fc_pkg;

    localparam int FC_FLATTENED_LENGTH = 50;
    localparam int FC_DATA_WIDTH       = 8;

`ifdef FC_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT
    } fc_load_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } fc_load_state_t;
`endif

endpackage

// File: rtl/fc_load_index_counter.sv
// Staging write index: clear/increment with terminal count at LENGTH-1.
// Wraps to zero after the last slot so it never leaves 0..LENGTH-1.
module fc_load_index_counter #(
    parameter int LENGTH = 50,
    localparam int IW = $clog2(LENGTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [IW-1:0] idx_o,
    output logic          tc_o
);

    localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    // Next index: clear wins, otherwise step and wrap after the last slot.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Index register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;
    assign tc_o  = (idx_q == LAST);

endmodule

// File: rtl/fc_weight_loader.sv
// Streams weights into a staging buffer and commits the full set with a
// one-cycle active-low write enable. Option: FC_LOADER_CHECKSUM_EN.
module fc_weight_loader
    import fc_pkg::*;
#(
    parameter int FLATTENED_LENGTH          = FC_FLATTENED_LENGTH,
    parameter int FULLYCONNECTED_DATA_WIDTH = FC_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load_start,
    input  logic load_abort,
    input  logic weight_in_valid,
    input  logic [FULLYCONNECTED_DATA_WIDTH-1:0] weight_in,
    output logic weight_in_ready,
    output logic [FULLYCONNECTED_DATA_WIDTH-1:0]
                 fullyconnected_weights_input [FLATTENED_LENGTH],
    output logic fullyconnected_WrEn,
    output logic busy,
    output logic load_done,
    output logic load_error
);

    localparam int W  = FULLYCONNECTED_DATA_WIDTH;
    localparam int IW = $clog2(FLATTENED_LENGTH);

    fc_load_state_t state_q;
    logic           wren_q;
    logic           done_q;
    logic           err_q;
    logic [W-1:0]   staging_q [FLATTENED_LENGTH];

    logic [IW-1:0]  idx;
    logic           idx_tc;
    logic           idx_clr;
    logic           idx_inc;

    assign idx_clr = (state_q == ST_IDLE) && load_start;
    assign idx_inc = (state_q == ST_LOAD) && weight_in_valid && !load_abort;

    fc_load_index_counter #(
        .LENGTH (FLATTENED_LENGTH)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr_i (idx_clr),
        .inc_i (idx_inc),
        .idx_o (idx),
        .tc_o  (idx_tc)
    );

`ifdef FC_LOADER_CHECKSUM_EN
    logic [W-1:0] sum_q;

    // Running sum of accepted weights, modulo 2^W.
    always_ff @(posedge clk) begin
        if (rst || idx_clr) begin
            sum_q <= '0;
        end else if (idx_inc) begin
            sum_q <= sum_q + weight_in;
        end
    end

    assign weight_in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
    assign weight_in_ready = (state_q == ST_LOAD);
`endif

    // Control FSM with registered WrEn, done and error strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wren_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wren_q <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_abort) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (weight_in_valid && idx_tc) begin
`ifdef FC_LOADER_CHECKSUM_EN
                        state_q <= ST_CHECK;
`else
                        state_q <= ST_COMMIT;
                        wren_q  <= 1'b0;
`endif
                    end
                end
`ifdef FC_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (load_abort) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (weight_in_valid) begin
                        if (weight_in == sum_q) begin
                            state_q <= ST_COMMIT;
                            wren_q  <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Staging buffer: one slot written per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLATTENED_LENGTH; i++) begin
                staging_q[i] <= '0;
            end
        end else if (idx_inc) begin
            staging_q[idx] <= weight_in;
        end
    end

    assign fullyconnected_weights_input = staging_q;
    assign fullyconnected_WrEn          = wren_q;
    assign busy                         = (state_q != ST_IDLE);
    assign load_done                    = done_q;
    assign load_error                   = err_q;

endmodule

// File: tb/tb_fc_weight_loader.sv
// Scoreboard bench for fc_weight_loader: driver pushes expected commit and
// error events, a negedge monitor pops and checks them.
module tb_fc_weight_loader;

    localparam int N  = 50;
    localparam int W  = 8;
    localparam int NB = N * W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic         load_abort = 1'b0;
    logic         v = 1'b0;
    logic [W-1:0] w = '0;
    logic         ready;
    logic [W-1:0] stg [N];
    logic         wren;
    logic         busy;
    logic         done;
    logic         err;

    fc_weight_loader #(
        .FLATTENED_LENGTH          (N),
        .FULLYCONNECTED_DATA_WIDTH (W)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .load_start                   (load_start),
        .load_abort                   (load_abort),
        .weight_in_valid              (v),
        .weight_in                    (w),
        .weight_in_ready              (ready),
        .fullyconnected_weights_input (stg),
        .fullyconnected_WrEn          (wren),
        .busy                         (busy),
        .load_done                    (done),
        .load_error                   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            commit;
        bit            done;
        int            at;
        logic [NB-1:0] img;
    } ev_t;

    ev_t          q[$];
    int           checks = 0;
    int           errors = 0;
    int           negcnt = 0;
    logic [W-1:0] model [N];
    logic [W-1:0] vec [N];

    function automatic logic [NB-1:0] pk_dut();
        logic [NB-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = stg[i];
        return r;
    endfunction

    function automatic logic [NB-1:0] pk_model();
        logic [NB-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = model[i];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] val, input bit stall);
        if (stall) begin
            v = 1'b0;
            tick();
        end
        v = 1'b1;
        w = val;
        tick();
        v = 1'b0;
    endtask

    task automatic push_commit(input bit d);
        ev_t e;
        e.commit = 1'b1;
        e.done   = d;
        e.at     = negcnt + 1;
        e.img    = pk_model();
        q.push_back(e);
    endtask

    task automatic push_error();
        ev_t e;
        e.commit = 1'b0;
        e.done   = 1'b0;
        e.at     = negcnt + 1;
        e.img    = '0;
        q.push_back(e);
    endtask

    // Full load of vec; returns at the start of the load_done cycle.
    task automatic full_load(input bit stall, input int start_at,
                             input bit rst_commit);
        logic [W-1:0] sum;
        sum = '0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == start_at) load_start = 1'b1;
            send(vec[i], stall);
            load_start = 1'b0;
            model[i] = vec[i];
            sum = sum + vec[i];
        end
`ifdef FC_LOADER_CHECKSUM_EN
        send(sum, stall);
`endif
        push_commit(!rst_commit);
        if (rst_commit) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            for (int i = 0; i < N; i++) model[i] = '0;
        end else begin
            tick();
        end
    endtask

    // Monitor: pops an expected event whenever WrEn or load_error shows.
    initial begin
        bit  pend;
        bit  pdone;
        ev_t e;
        pend  = 1'b0;
        pdone = 1'b0;
        forever begin
            @(negedge clk);
            negcnt++;
            if (pend) begin
                pend = 1'b0;
                checks++;
                if (done !== pdone || wren !== 1'b1 ||
                    (pdone && busy !== 1'b0)) begin
                    errors++;
                    $display("FAIL done_pulse: got done=%b wren=%b busy=%b want done=%b wren=1 busy=0",
                             done, wren, busy, pdone);
                end
            end else if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stray_done: got %b want 0", done);
            end
            if (wren !== 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_wren: got wren=%b at %0d want 1", wren, negcnt);
                end else begin
                    e = q.pop_front();
                    if (!e.commit || e.at != negcnt || pk_dut() !== e.img) begin
                        errors++;
                        $display("FAIL commit: got at=%0d img=%h want commit=%b at=%0d img=%h",
                                 negcnt, pk_dut(), e.commit, e.at, e.img);
                    end
                    pend  = 1'b1;
                    pdone = e.done;
                end
            end
            if (err !== 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_error: got err=%b at %0d want 0", err, negcnt);
                end else begin
                    e = q.pop_front();
                    if (e.commit || e.at != negcnt || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL error_pulse: got at=%0d busy=%b want commit=%b at=%0d busy=0",
                                 negcnt, busy, e.commit, e.at);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) model[i] = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_wren",  int'(wren),  1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_err",   int'(err),   0);
        chk("rst_stg",   int'(pk_dut() == '0), 1);

        // 1..50 streamed back-to-back
        for (int i = 0; i < N; i++) vec[i] = W'(i + 1);
        full_load(1'b0, -1, 1'b0);
        tick();
        chk("t1_busy",  int'(busy),    0);
        chk("t1_stg0",  int'(stg[0]),  1);
        chk("t1_stg49", int'(stg[49]), 50);

        // same data with a stall before every beat
        full_load(1'b1, -1, 1'b0);
        tick();
        chk("t2_busy", int'(busy), 0);

        // abort after 20 beats; beat presented with abort is dropped
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(W'(100 + i), 1'b0);
            model[i] = W'(100 + i);
        end
        load_abort = 1'b1;
        v = 1'b1;
        w = 8'hEE;
        tick();
        push_error();
        load_abort = 1'b0;
        v = 1'b0;
        tick();
        chk("ab_busy",  int'(busy),    0);
        chk("ab_stg19", int'(stg[19]), 119);
        chk("ab_stg20", int'(stg[20]), 21);

        // full 0xAA load, then back-to-back load with a stray load_start
        for (int i = 0; i < N; i++) vec[i] = 8'hAA;
        full_load(1'b0, -1, 1'b0);
        chk("aa_stg25", int'(stg[25]), 8'hAA);
        for (int i = 0; i < N; i++) vec[i] = W'(60 + i);
        full_load(1'b0, 10, 1'b0);
        tick();
        chk("st_stg10", int'(stg[10]), 70);
        chk("st_stg49", int'(stg[49]), 109);

`ifdef FC_LOADER_CHECKSUM_EN
        for (int i = 0; i < N; i++) vec[i] = 8'h05;
        full_load(1'b0, -1, 1'b0);
        tick();
        chk("cs_ok_stg0", int'(stg[0]), 5);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < N; i++) send(8'h05, 1'b0);
        send(8'hFB, 1'b0);
        push_error();
        tick();
        chk("cs_bad_busy", int'(busy), 0);
`endif

        // reset lands on the edge that ends the COMMIT cycle
        for (int i = 0; i < N; i++) vec[i] = W'(i) ^ 8'h3C;
        full_load(1'b0, -1, 1'b1);
        chk("rc_wren",  int'(wren),  1);
        chk("rc_ready", int'(ready), 0);
        chk("rc_busy",  int'(busy),  0);
        chk("rc_stg",   int'(pk_dut() == '0), 1);

        repeat (4) tick();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
